// File: rtl/jtag_master_pkg.sv
// Shared encodings for the JTAG master engine: command opcodes and FSM states.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET     = 2'd0,
        OP_TMS_SEQ   = 2'd1,
        OP_SCAN      = 2'd2,
        OP_SCAN_FLIP = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOW, S_HIGH, S_PUSH, S_DONE
    } state_e;

    function automatic logic is_scan(op_e op);
        return (op == OP_SCAN) || (op == OP_SCAN_FLIP);
    endfunction

endpackage

// File: rtl/jtag_master_engine_if.sv
// Command, TDI-word and TDO-word valid/ready channels between host decoder and engine.
interface jtag_master_engine_if #(
    parameter int DATA_W  = 32,
    parameter int NBITS_W = 16
);
    import jtag_master_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    op_e                cmd_op;
    logic [NBITS_W-1:0] cmd_nbits;
    logic               din_valid;
    logic               din_ready;
    logic [DATA_W-1:0]  din_data;
    logic               dout_valid;
    logic               dout_ready;
    logic [DATA_W-1:0]  dout_data;

    modport master (
        output cmd_valid, cmd_op, cmd_nbits, din_valid, din_data, dout_ready,
        input  cmd_ready, din_ready, dout_valid, dout_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_nbits, din_valid, din_data, dout_ready,
        output cmd_ready, din_ready, dout_valid, dout_data
    );

endinterface

// File: rtl/jtag_tck_div.sv
// TCK phase timer: counts CLK_DIV cycles per phase while enabled, flags first and last cycle.
module jtag_tck_div #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic ph_start,
    output logic ph_end
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Restart on every phase end so LOW and HIGH each get a full CLK_DIV window
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (!en || ph_end) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end

    assign ph_start = en && (cnt == '0);
    assign ph_end   = en && (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/jtag_master_engine.sv
// JTAG master: runs RESET / TMS_SEQ / SCAN / SCAN_FLIP_TMS on TCK/TMS/TDI/TDO pins,
// TCK pausing low whenever the TDI or TDO word stream stalls.
module jtag_master_engine
    import jtag_master_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NBITS_W    = 16,
    parameter int CLK_DIV    = 5,
    parameter int RESET_CLKS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    jtag_master_engine_if.slave  bus,
    output logic                 cmd_done,
    output logic                 busy,
    output logic                 tck,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo
);
    localparam int SHL_W = $clog2(DATA_W + 1);
    localparam int CI_W  = $clog2(DATA_W);

    state_e             state, state_n;
    op_e                op, op_n;
    logic [NBITS_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0]  sh, sh_n, cap, cap_n, dd, dd_n;
    logic [SHL_W-1:0]   shl, shl_n;
    logic [CI_W-1:0]    cidx, cidx_n;
    logic               dv, dv_n, tms_n, tdi_n;
    logic               ph_start, ph_end;

    jtag_tck_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk(clk), .rst(rst), .en(state == S_LOW || state == S_HIGH),
        .ph_start(ph_start), .ph_end(ph_end)
    );

    always_comb begin
        state_n = state;  op_n = op;  cnt_n = cnt;  sh_n = sh;  shl_n = shl;
        cap_n = cap;  cidx_n = cidx;  dd_n = dd;
        dv_n = dv && !bus.dout_ready;
        tms_n = tms;  tdi_n = tdi;
        bus.cmd_ready = 1'b0;
        bus.din_ready = 1'b0;
        case (state)
            S_IDLE: begin
                bus.cmd_ready = !rst;
                if (bus.cmd_valid) begin
                    op_n = bus.cmd_op;  shl_n = '0;  cap_n = '0;  cidx_n = '0;
                    if (bus.cmd_op == OP_RESET) begin
                        cnt_n   = NBITS_W'(RESET_CLKS + 1);
                        state_n = S_LOW;
                    end else begin
                        cnt_n   = bus.cmd_nbits;
                        state_n = (bus.cmd_nbits == '0) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_FETCH: if (bus.din_valid) begin
                bus.din_ready = 1'b1;
                sh_n    = bus.din_data;
                shl_n   = SHL_W'(DATA_W);
                state_n = S_LOW;
            end
            S_LOW: if (ph_end) state_n = S_HIGH;
            S_HIGH: begin
                if (ph_start) cap_n[cidx] = tdo;
                if (ph_end) begin
                    cnt_n  = cnt - 1'b1;
                    sh_n   = sh >> 1;
                    shl_n  = shl - 1'b1;
                    cidx_n = (cidx == CI_W'(DATA_W - 1)) ? '0 : cidx + 1'b1;
                    if (is_scan(op) && (cnt == NBITS_W'(1) || cidx == CI_W'(DATA_W - 1)))
                        state_n = S_PUSH;
                    else if (cnt == NBITS_W'(1))
                        state_n = S_DONE;
                    else if (op != OP_RESET && shl == SHL_W'(1))
                        state_n = S_FETCH;
                    else
                        state_n = S_LOW;
                end
            end
            S_PUSH: if (!dv || bus.dout_ready) begin
                dv_n  = 1'b1;
                dd_n  = cap;
                cap_n = '0;  // zero-fills the upper bits of a final partial word
                if (cnt == '0)      state_n = S_DONE;
                else if (shl == '0) state_n = S_FETCH;
                else                state_n = S_LOW;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Pins change only when a bit period begins, so they are stable across the TCK rise
        if (state_n == S_LOW) begin
            case (op_n)
                OP_RESET:   begin tms_n = (cnt_n != NBITS_W'(1)); tdi_n = 1'b0;    end
                OP_TMS_SEQ: begin tms_n = sh_n[0];                tdi_n = 1'b0;    end
                OP_SCAN:    begin tms_n = 1'b0;                   tdi_n = sh_n[0]; end
                default:    begin tms_n = (cnt_n == NBITS_W'(1)); tdi_n = sh_n[0]; end
            endcase
        end else if (state_n == S_DONE || state_n == S_IDLE) begin
            tms_n = 1'b0;
            tdi_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;  op <= OP_RESET;  cnt <= '0;  sh <= '0;  shl <= '0;
            cap <= '0;  cidx <= '0;  dv <= 1'b0;  dd <= '0;
            tck <= 1'b0;  tms <= 1'b0;  tdi <= 1'b0;
        end else begin
            state <= state_n;  op <= op_n;  cnt <= cnt_n;  sh <= sh_n;  shl <= shl_n;
            cap <= cap_n;  cidx <= cidx_n;  dv <= dv_n;  dd <= dd_n;
            tck <= (state_n == S_HIGH);
            tms <= tms_n;
            tdi <= tdi_n;
        end
    end

    assign bus.dout_valid = dv;
    assign bus.dout_data  = dd;
    assign cmd_done       = (state == S_DONE);
    assign busy           = (state != S_IDLE) || dv;

endmodule

// File: tb/tb_jtag_master_engine.sv
// Bench for jtag_master_engine: command vector table with TDO looped to TDI,
// dout scoreboard, plus stall and mid-command reset sequences.
module tb_jtag_master_engine;
    import jtag_master_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_done, busy, tck, tms, tdi, tdo;

    jtag_master_engine_if #(.DATA_W(32), .NBITS_W(16)) bif ();

    jtag_master_engine #(.DATA_W(32), .NBITS_W(16), .CLK_DIV(5), .RESET_CLKS(5)) dut (
        .clk(clk), .rst(rst), .bus(bif), .cmd_done(cmd_done), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;
    assign tdo = tdi;

    typedef struct packed {
        op_e              op;
        logic [15:0]      nbits;
        logic [1:0][31:0] din;
        int               ndin;
        int               nedges;
        logic [63:0]      exp_tms;
        logic [63:0]      exp_tdi;
        int               ndout;
        logic [1:0][31:0] dout;
        bit               stall;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Cumulative activity counters, sampled on the falling clk edge
    int   cyc = 0, rises = 0, dones = 0, dins = 0, douts = 0;
    logic etms [0:1023];
    logic etdi [0:1023];
    int   rcyc [0:1023];
    logic tck_d = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (tck && !tck_d) begin
            if (rises < 1024) begin
                etms[rises] = tms;
                etdi[rises] = tdi;
                rcyc[rises] = cyc;
            end
            rises++;
        end
        tck_d = tck;
        if (cmd_done) dones++;
        if (bif.din_valid && bif.din_ready) dins++;
        if (bif.dout_valid && bif.dout_ready) douts++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(op_e op, int nb, logic [31:0] d0, logic [31:0] d1, int ndin,
                                int ne, logic [63:0] etm, logic [63:0] etd, int ndout,
                                logic [31:0] o0, logic [31:0] o1, bit stall);
        vec_t v;
        v.op = op;  v.nbits = 16'(nb);  v.din[0] = d0;  v.din[1] = d1;  v.ndin = ndin;
        v.nedges = ne;  v.exp_tms = etm;  v.exp_tdi = etd;  v.ndout = ndout;
        v.dout[0] = o0;  v.dout[1] = o1;  v.stall = stall;
        return v;
    endfunction

    task automatic issue(input op_e op, input int nb);
        int t = 0;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b1;  bif.cmd_op = op;  bif.cmd_nbits = 16'(nb);
        do begin @(negedge clk); t++; end while (!bif.cmd_ready && t < 100);
        chk("cmd_accept", bif.cmd_ready, 1);
        @(posedge clk); #1 bif.cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w);
        int t = 0;
        bif.din_valid = 1'b1;  bif.din_data = w;
        do begin @(negedge clk); t++; end while (!bif.din_ready && t < 3000);
        chk("din_taken", bif.din_ready, 1);
        @(posedge clk); #1 bif.din_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int r0, dn0, di0, do0, mn, mx, d;
        logic [63:0] at, ad;
        logic [31:0] sb [$];
        r0 = rises;  dn0 = dones;  di0 = dins;  do0 = douts;
        issue(v.op, int'(v.nbits));
        fork
            begin
                int t;
                bit bad;
                for (int w = 0; w < v.ndin; w++) begin
                    if (v.stall && w == 1) begin
                        t = 0;
                        do begin @(negedge clk); t++; end while (!(rises - r0 >= 32 && !tck) && t < 3000);
                        bad = 1'b0;
                        repeat (50) begin @(negedge clk); if (tck) bad = 1'b1; end
                        chk("din_stall_tck_low", bad, 0);
                        @(posedge clk); #1;
                    end
                    if (w < v.ndout) sb.push_back(v.dout[w]);
                    feed(v.din[w]);
                end
            end
            begin
                int t, got;
                bit bad;
                logic [31:0] e;
                got = 0;
                if (v.stall) begin
                    bif.dout_ready = 1'b0;
                    t = 0;
                    do begin @(negedge clk); t++; end while (!(rises - r0 >= v.nedges && !tck) && t < 5000);
                    bad = 1'b0;
                    repeat (30) begin @(negedge clk); if (tck || cmd_done) bad = 1'b1; end
                    chk("dout_stall_tck_low", bad, 0);
                    @(posedge clk); #1 bif.dout_ready = 1'b1;
                end
                t = 0;
                while (got < v.ndout && t < 5000) begin
                    @(negedge clk); t++;
                    if (bif.dout_valid && bif.dout_ready) begin
                        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
                        chk($sformatf("dout_word v%0d w%0d", idx, got), bif.dout_data, e);
                        got++;
                    end
                end
                chk("dout_words_seen", got, v.ndout);
            end
            begin
                int lat = 0;
                do begin @(negedge clk); lat++; end while (!cmd_done && lat < 5000);
                chk("cmd_done_seen", cmd_done, 1);
                if (v.op != OP_RESET && v.nbits == 0) chk("zero_len_latency_le2", lat <= 2, 1);
            end
        join
        d = 0;
        while (busy && d < 1000) begin @(negedge clk); d++; end
        repeat (3) @(negedge clk);
        at = '0;  ad = '0;  mn = 1 << 30;  mx = 0;
        for (int k = 0; k < v.nedges && k < 64; k++) begin
            at[k] = etms[r0 + k];
            ad[k] = etdi[r0 + k];
        end
        for (int k = 1; k < v.nedges; k++) begin
            d = rcyc[r0 + k] - rcyc[r0 + k - 1];
            if (d < mn) mn = d;
            if (d > mx) mx = d;
        end
        chk($sformatf("v%0d tck_edges", idx), rises - r0, v.nedges);
        chk($sformatf("v%0d tms_bits", idx), at, v.exp_tms);
        chk($sformatf("v%0d tdi_bits", idx), ad, v.exp_tdi);
        chk($sformatf("v%0d din_words", idx), dins - di0, v.ndin);
        chk($sformatf("v%0d dout_words", idx), douts - do0, v.ndout);
        chk($sformatf("v%0d cmd_done_pulses", idx), dones - dn0, 1);
        chk($sformatf("v%0d tms_after", idx), tms, 0);
        chk($sformatf("v%0d tdi_after", idx), tdi, 0);
        chk($sformatf("v%0d scoreboard_empty", idx), sb.size(), 0);
        if (v.nedges >= 2) chk($sformatf("v%0d tck_min_period", idx), mn, 10);
        if (v.nedges >= 2 && v.nedges <= 32) chk($sformatf("v%0d tck_max_period", idx), mx, 10);
    endtask

    initial begin
        vec_t vt [8];
        int r0, dn0, t;

        bif.cmd_valid = 1'b0;  bif.cmd_op = OP_RESET;  bif.cmd_nbits = '0;
        bif.din_valid = 1'b0;  bif.din_data = '0;  bif.dout_ready = 1'b1;

        vt[0] = mk(OP_RESET,      7, 32'h0, 32'h0, 0, 6, 64'h1F, 64'h0, 0, 32'h0, 32'h0, 1'b0);
        vt[1] = mk(OP_TMS_SEQ,    6, 32'h0000001B, 32'h0, 1, 6, 64'h1B, 64'h0, 0, 32'h0, 32'h0, 1'b0);
        vt[2] = mk(OP_SCAN,      40, 32'hA5A5A5A5, 32'h0000003C, 2, 40, 64'h0, 64'h0000003C_A5A5A5A5,
                   2, 32'hA5A5A5A5, 32'h0000003C, 1'b0);
        vt[3] = mk(OP_SCAN_FLIP,  8, 32'hFFFFFF96, 32'h0, 1, 8, 64'h80, 64'h96, 1, 32'h00000096, 32'h0, 1'b0);
        vt[4] = mk(OP_SCAN,       0, 32'h0, 32'h0, 0, 0, 64'h0, 64'h0, 0, 32'h0, 32'h0, 1'b0);
        vt[5] = mk(OP_TMS_SEQ,   33, 32'hFFFF0000, 32'h00000003, 2, 33, 64'h1_FFFF0000, 64'h0, 0, 32'h0, 32'h0, 1'b0);
        vt[6] = mk(OP_SCAN,      32, 32'h80000001, 32'h0, 1, 32, 64'h0, 64'h80000001, 1, 32'h80000001, 32'h0, 1'b0);
        vt[7] = mk(OP_SCAN,      64, 32'h12345678, 32'hDEADBEEF, 2, 64, 64'h0, 64'hDEADBEEF_12345678,
                   2, 32'h12345678, 32'hDEADBEEF, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 0);
        chk("rst_tdi", tdi, 0);
        chk("rst_dout_valid", bif.dout_valid, 0);
        chk("rst_dout_data", bif.dout_data, 0);
        chk("rst_cmd_done", cmd_done, 0);
        chk("rst_din_ready", bif.din_ready, 0);
        chk("rst_cmd_ready", bif.cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", bif.cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Reset in the middle of a scan: everything drops, no completion pulse
        r0 = rises;
        issue(OP_SCAN, 64);
        feed(32'hCAFEF00D);
        t = 0;
        do begin @(negedge clk); t++; end while (rises - r0 < 10 && t < 2000);
        chk("midrst_edges_before", rises - r0 >= 10, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_tck", tck, 0);
        chk("midrst_tms", tms, 0);
        chk("midrst_tdi", tdi, 0);
        chk("midrst_dout_valid", bif.dout_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_done", cmd_done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dn0 = dones;  r0 = rises;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", dones - dn0, 0);
        chk("midrst_no_tck", rises - r0, 0);
        chk("midrst_cmd_ready", bif.cmd_ready, 1);

        run_vec(vt[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_master_engine.md
Name: jtag_master_engine

Overview:
Synthesizable, clocked JTAG master for FPGA-resident debug bridges. It executes the four JTAG commands RESET, TMS_SEQ, SCAN_CHAIN and SCAN_CHAIN_FLIP_TMS on real TCK/TMS/TDI/TDO pins. Commands arrive on a valid/ready port; TDI data enters and captured TDO data leaves on DATA_W-wide valid/ready streams. TCK is divided from the system clock and pauses low when either stream stalls. It sits between a host-side command decoder (UART/USB/Wishbone bridge) and the on-chip or board TAP.

Parameters:
DATA_W, 32, stream word width; bits are packed LSB-first into words.
NBITS_W, 16, width of the bit-count field; max 2^NBITS_W-1 bits per command.
CLK_DIV, 5, TCK half period in clk cycles (>=1).
RESET_CLKS, 5, number of TMS=1 clocks issued by RESET.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine accepts command (high only in IDLE)
cmd_op  in  2  0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP_TMS
cmd_nbits  in  NBITS_W  number of bits; ignored for RESET
din_valid  in  1  TMS/TDI word valid
din_ready  out  1  word consumed this cycle
din_data  in  DATA_W  TMS bits (TMS_SEQ) or TDI bits (SCAN)
dout_valid  out  1  captured TDO word valid (SCAN ops only)
dout_ready  in  1  downstream takes word
dout_data  out  DATA_W  TDO bits, LSB = first captured
cmd_done  out  1  one-cycle pulse at command completion
busy  out  1  not IDLE or dout_valid pending
tck  out  1  JTAG clock
tms  out  1  JTAG mode select
tdi  out  1  JTAG data in
tdo  in  1  JTAG data out (synchronised externally)

Behaviour:
- Reset values: tck=0, tms=0, tdi=0, dout_valid=0, dout_data=0, cmd_done=0, din_ready=0. cmd_ready goes high the first cycle after reset deasserts.
- States: IDLE, FETCH, LOW, HIGH, PUSH, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch op and nbits into the bit counter; go to FETCH. nbits=0 (non-RESET) goes directly to DONE: no TCK, no din/dout traffic.
- RESET: runs RESET_CLKS bit periods with tms=1, then one with tms=0, tdi=0, no streams; ends in Run-Test/Idle.
- FETCH: entered when the input shift register is empty. Wait for din_valid; din_ready pulses for exactly one cycle when loading. tck stays 0 while waiting.
- LOW: drive tms/tdi from bit 0 of the shift register on entry.
  - TMS_SEQ: tdi=0.
  - SCAN: tms=0, except tms=1 on the final bit of SCAN_FLIP_TMS.
  - Hold tck=0 for CLK_DIV cycles.
- HIGH: tck=1 for CLK_DIV cycles. tdo is sampled into the capture register at bit index (count mod DATA_W) in the first HIGH cycle.
- After HIGH: decrement the count and shift the input register.
  - Capture word full, or last bit: go to PUSH (SCAN only).
  - Else input word exhausted and bits remain: FETCH.
  - Else: LOW.
- PUSH: wait until the holding register is empty (dout_valid=0 or dout_ready this cycle), load it, assert dout_valid, then continue. The final partial word has its upper bits zero-filled. tck stays 0 while waiting.
- DONE: tms=0, tdi=0; pulse cmd_done for one cycle, return to IDLE. A pending dout word may still be outstanding; busy stays high until it is taken.
- Word counts: ceil(nbits/DATA_W) din words consumed; the same number of dout words for SCAN ops, none for TMS_SEQ/RESET. Unused upper bits of the last din word are ignored.
- cmd_valid while not IDLE: not accepted, no effect.
- rst mid-command: immediately apply reset values. Partial words are discarded and no cmd_done is issued. The TAP state is undefined; the host issues RESET.

Decomposition:
- Package jtag_master_pkg: op encodings (OP_RESET, OP_TMS_SEQ, OP_SCAN, OP_SCAN_FLIP) and the state enum.
- One sub-module, jtag_tck_div: a CLK_DIV counter with enable that produces phase-end strobes.
- Shift, capture and the FSM stay in the top module.

Test Plan:
- Reset then OP_RESET:
  - tms=1 for exactly 5 tck rising edges, then one with tms=0.
  - tck period = 2*CLK_DIV = 10 clk cycles.
  - cmd_done pulses once.
- OP_TMS_SEQ, nbits=6, din=0x0000001B:
  - tms at successive rising edges = 1,1,0,1,1,0.
  - One din word consumed, no dout, tdi=0 throughout.
- OP_SCAN, nbits=40, din words 0xA5A5A5A5 and 0x0000003C, tdo looped to tdi:
  - dout = 0xA5A5A5A5, then 0x0000003C with upper 24 bits 0.
  - tms=0 on all edges.
- OP_SCAN_FLIP_TMS, nbits=8:
  - tms=1 only at the 8th rising edge.
  - tms=0 and tdi=0 after completion.
- Stall cases:
  - din_valid withheld 50 cycles between words and dout_ready low 30 cycles during a 64-bit scan: tck stays 0 during each stall, no bit lost, data intact.
  - cmd_nbits=0: cmd_done pulses within 2 cycles, zero tck edges.
  - rst mid-scan: outputs reset, no cmd_done.
